program_loader: RTL and testbench

Streaming loader that drives the program memory's write port (`pgm`, `addr`, `data`). It accepts a framed byte stream from a serial front end, such as a UART receiver, over a valid/ready handshake. It packs the bytes little-endian into STEP-byte instruction words, writes them to consecutive addresses starting at 0, and checks a trailer checksum. While a frame is in progress it holds the core in reset through `cpu_hold`.

---
 rtl/program_loader_pkg.sv | 16 +
 rtl/loader_word_packer.sv | 44 ++++
 rtl/program_loader.sv | 91 +++++++++
 tb/tb_program_loader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared framing definitions for the program loader
package program_loader_pkg;

  // Default frame start byte, reused by any future transmitter/dumper of this framing
  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_LO = 3'd1,
    CNT_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    FIN    = 3'd5
  } state_t;

endpackage

// File: rtl/loader_word_packer.sv
// rtl/loader_word_packer.sv - little-endian byte-to-word packer with running payload sum
module loader_word_packer #(
  parameter int STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [STEP*8-1:0] word_next,
  output logic              word_full,
  output logic [7:0]        sum
);

  localparam logic [2:0] LAST = 3'(STEP - 1);

  logic [STEP*8-1:0] shreg;
  logic [2:0]        idx;

  // Word including the byte being accepted this cycle, so the write can issue on the same edge
  always_comb begin
    word_next = shreg;
    word_next[idx*8 +: 8] = byte_in;
  end

  assign word_full = byte_en && (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      idx   <= '0;
      sum   <= '0;
    end else if (clear) begin
      shreg <= '0;
      idx   <= '0;
      sum   <= '0;
    end else if (byte_en) begin
      shreg <= word_next;
      sum   <= sum + byte_in;
      idx   <= word_full ? 3'd0 : idx + 3'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader driving the program memory write port
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         INSTR_ADDR_WIDTH = 20,
  parameter int         STEP             = 4,
  parameter logic [7:0] MAGIC            = DEFAULT_MAGIC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic                        pgm,
  output logic [INSTR_ADDR_WIDTH-1:0] addr,
  output logic [STEP*8-1:0]           data,
  output logic                        cpu_hold,
  output logic                        done,
  output logic                        err
);

  state_t                      state, state_nx;
  logic [7:0]                  cnt_lo;
  logic [15:0]                 words_left;
  logic [INSTR_ADDR_WIDTH-1:0] wr_addr;
  logic                        chk_ok;
  logic                        accept;
  logic                        byte_en;
  logic                        word_full;
  logic [STEP*8-1:0]           word_next;
  logic [7:0]                  sum;

  // Outputs derive from registered state so an async reset clears them without a clock
  assign rx_ready = rst_n && (state != FIN);
  assign accept   = rx_valid && rx_ready;
  assign byte_en  = accept && (state == DATA);
  assign cpu_hold = (state != IDLE);
  assign done     = (state == FIN) && chk_ok;
  assign err      = (state == FIN) && !chk_ok;

  loader_word_packer #(.STEP(STEP)) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state == IDLE),
    .byte_en   (byte_en),
    .byte_in   (rx_data),
    .word_next (word_next),
    .word_full (word_full),
    .sum       (sum)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (accept && rx_data == MAGIC) state_nx = CNT_LO;
      CNT_LO: if (accept) state_nx = CNT_HI;
      CNT_HI: if (accept) state_nx = ({rx_data, cnt_lo} == 16'd0) ? CHECK : DATA;
      DATA:   if (word_full && words_left == 16'd1) state_nx = CHECK;
      CHECK:  if (accept) state_nx = FIN;
      FIN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt_lo     <= '0;
      words_left <= '0;
      wr_addr    <= '0;
      chk_ok     <= 1'b0;
      pgm        <= 1'b0;
      addr       <= '0;
      data       <= '0;
    end else begin
      state <= state_nx;
      pgm   <= word_full;
      if (state == IDLE) wr_addr <= '0;
      if (accept && state == CNT_LO) cnt_lo <= rx_data;
      if (accept && state == CNT_HI) words_left <= {rx_data, cnt_lo};
      if (accept && state == CHECK) chk_ok <= (rx_data == sum);
      if (word_full) begin
        addr       <= wr_addr;
        data       <= word_next;
        wr_addr    <= wr_addr + INSTR_ADDR_WIDTH'(1);
        words_left <= words_left - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  localparam int AW   = 5;
  localparam int STEP = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_valid = 1'b0;
  logic            rx_ready;
  logic            pgm;
  logic [AW-1:0]   addr;
  logic [STEP*8-1:0] data;
  logic            cpu_hold;
  logic            done;
  logic            err;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0]     wa[$];
  logic [STEP*8-1:0] wd[$];
  int done_cnt = 0;
  int err_cnt  = 0;

  program_loader #(.INSTR_ADDR_WIDTH(AW), .STEP(STEP), .MAGIC(8'hA5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .pgm      (pgm),
    .addr     (addr),
    .data     (data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pgm) begin
      wa.push_back(addr);
      wd.push_back(data);
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one rising edge, returning 1 time unit after it
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic clear_log();
    @(negedge clk);
    wa.delete();
    wd.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_pgm", 64'(pgm), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check("rst_done_err", 64'({done, err}), 64'd0);
    check("rst_addr_data", 64'({addr, data}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_rx_ready", 64'(rx_ready), 64'd1);

    // Idle-line noise
    clear_log();
    send(8'h00); check("noise0_hold", 64'(cpu_hold), 64'd0);
    send(8'hFF); check("noise1_hold", 64'(cpu_hold), 64'd0);
    send(8'h13); check("noise2_hold", 64'(cpu_hold), 64'd0);
    @(negedge clk);
    check("noise_writes", 64'(wa.size()), 64'd0);

    // Good frame, N=2
    clear_log();
    send(8'hA5); check("magic_hold", 64'(cpu_hold), 64'd1);
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00);
    check("w0_no_early_pgm", 64'(pgm), 64'd0);
    send(8'h00);
    check("w0_pgm", 64'(pgm), 64'd1);
    check("w0_addr", 64'(addr), 64'd0);
    check("w0_data", 64'(data), 64'h00000013);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    check("w1_hold", 64'(cpu_hold), 64'd1);
    send(8'hB6);
    check("good_done", 64'(done), 64'd1);
    check("good_err", 64'(err), 64'd0);
    check("good_fin_hold", 64'(cpu_hold), 64'd1);
    check("good_fin_ready", 64'(rx_ready), 64'd0);
    @(posedge clk); #1;
    check("good_done_pulse", 64'(done), 64'd0);
    check("good_hold_fall", 64'(cpu_hold), 64'd0);
    @(negedge clk);
    check("good_nwrites", 64'(wa.size()), 64'd2);
    if (wa.size() == 2) begin
      check("good_a0", 64'(wa[0]), 64'd0);
      check("good_d0", 64'(wd[0]), 64'h00000013);
      check("good_a1", 64'(wa[1]), 64'd1);
      check("good_d1", 64'(wd[1]), 64'h00100093);
    end
    check("good_done_cnt", 64'(done_cnt), 64'd1);

    // Same frame, bad checksum
    clear_log();
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    send(8'h00);
    check("bad_err", 64'(err), 64'd1);
    check("bad_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    check("bad_nwrites", 64'(wa.size()), 64'd2);
    if (wa.size() == 2) check("bad_a1", 64'(wa[1]), 64'd1);
    check("bad_cnts", 64'({done_cnt[7:0], err_cnt[7:0]}), 64'h0001);

    // Empty frame
    clear_log();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    check("n0_done", 64'(done), 64'd1);
    repeat (2) @(negedge clk);
    check("n0_nwrites", 64'(wa.size()), 64'd0);
    check("n0_hold", 64'(cpu_hold), 64'd0);

    // Address wrap: 33 words with data equal to word index, sum = 528 mod 256 = 0x10
    clear_log();
    send(8'hA5); send(8'h21); send(8'h00);
    for (int i = 0; i < 33; i++) begin
      send(8'(i)); send(8'h00); send(8'h00); send(8'h00);
    end
    send(8'h10);
    check("wrap_done", 64'(done), 64'd1);
    repeat (2) @(negedge clk);
    check("wrap_nwrites", 64'(wa.size()), 64'd33);
    if (wa.size() == 33) begin
      check("wrap_a31", 64'(wa[31]), 64'd31);
      check("wrap_a32", 64'(wa[32]), 64'd0);
      check("wrap_d32", 64'(wd[32]), 64'd32);
    end

    // Reset mid-word, then fresh frame
    clear_log();
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h11); send(8'h22);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_hold", 64'(cpu_hold), 64'd0);
    check("mid_rst_ready", 64'(rx_ready), 64'd0);
    check("mid_rst_outs", 64'({pgm, done, err, addr, data}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    send(8'hAA);
    check("fresh_done", 64'(done), 64'd1);
    repeat (2) @(negedge clk);
    check("fresh_nwrites", 64'(wa.size()), 64'd1);
    if (wa.size() == 1) begin
      check("fresh_a0", 64'(wa[0]), 64'd0);
      check("fresh_d0", 64'(wd[0]), 64'h11223344);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
